// File: rtl/fcl_neuron_accum_if.sv
// fcl_neuron_accum_if: partial-sum input stream and neuron result output stream
// of the fully-connected layer-1 neuron accumulator.
interface fcl_neuron_accum_if #(
    parameter int PSUM_WIDTH = 19,
    parameter int OUT_WIDTH  = 16,
    parameter int IDX_WIDTH  = 7
);
    logic [PSUM_WIDTH-1:0] neuron_acc_psum_i;
    logic                  neuron_acc_psum_valid_i;
    logic                  neuron_acc_psum_ready_o;
    logic [OUT_WIDTH-1:0]  neuron_acc_bias_i;
    logic [OUT_WIDTH-1:0]  neuron_acc_out_o;
    logic [IDX_WIDTH-1:0]  neuron_acc_idx_o;
    logic                  neuron_acc_out_valid_o;
    logic                  neuron_acc_out_ready_i;
    modport master (
        output neuron_acc_psum_i, neuron_acc_psum_valid_i, neuron_acc_bias_i, neuron_acc_out_ready_i,
        input  neuron_acc_psum_ready_o, neuron_acc_out_o, neuron_acc_idx_o, neuron_acc_out_valid_o
    );
    modport slave (
        input  neuron_acc_psum_i, neuron_acc_psum_valid_i, neuron_acc_bias_i, neuron_acc_out_ready_i,
        output neuron_acc_psum_ready_o, neuron_acc_out_o, neuron_acc_idx_o, neuron_acc_out_valid_o
    );
endinterface

// File: rtl/fcl_neuron_accum.sv
// fcl_neuron_accum: accumulates NUM_PARTIALS partial sums, adds a bias, saturates and
// emits one indexed neuron result. Define FCL_NEURON_ACC_RELU_EN to clamp negatives to 0.
module fcl_neuron_accum #(
    parameter int OPERAND_WIDTH = 8,
    parameter int PSUM_WIDTH    = 2*OPERAND_WIDTH+3,
    parameter int NUM_PARTIALS  = 40,
    parameter int NUM_NEURONS   = 120,
    parameter int OUT_WIDTH     = 16,
    parameter int ACC_WIDTH     = PSUM_WIDTH+$clog2(NUM_PARTIALS)+2
) (
    input logic               neuron_acc_clk,
    input logic               neuron_acc_rst,
    fcl_neuron_accum_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_PARTIALS+1);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2**(OUT_WIDTH-1)-1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]       cnt_q, cnt_d;
    logic        [OUT_WIDTH-1:0]   bias_q, bias_d;
    logic        [OUT_WIDTH-1:0]   out_q, out_d;
    logic        [IDX_W-1:0]       idx_q, idx_d;
    logic                          valid_q, valid_d;
    logic                          psum_ready;
    logic                          accept;
    logic                          out_fire;
    logic                          last_beat;
    logic signed [ACC_WIDTH-1:0]   psum_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic        [OUT_WIDTH-1:0]   out_sat;

    always_ff @(posedge neuron_acc_clk or posedge neuron_acc_rst) begin
        if (neuron_acc_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = (NUM_PARTIALS == 1) ? BIAS : ACCUM;
            ACCUM: if (accept && last_beat) state_d = BIAS;
            BIAS:  state_d = OUT;
            OUT:   if (out_fire) state_d = IDLE;
        endcase
    end

    always_comb begin
        psum_ready                  = (state_q == IDLE) || (state_q == ACCUM);
        bus.neuron_acc_psum_ready_o = psum_ready;
        bus.neuron_acc_out_o        = out_q;
        bus.neuron_acc_idx_o        = idx_q;
        bus.neuron_acc_out_valid_o  = valid_q;
    end

    // The bias is folded into the accumulator during BIAS; the first OUT cycle then
    // registers the saturated value, so valid rises two edges after the last beat.
    always_comb begin
        accept    = bus.neuron_acc_psum_valid_i && psum_ready;
        out_fire  = valid_q && bus.neuron_acc_out_ready_i;
        last_beat = cnt_q == CNT_W'(NUM_PARTIALS-1);
        psum_ext  = ACC_WIDTH'($signed(bus.neuron_acc_psum_i));
        bias_ext  = ACC_WIDTH'($signed(bias_q));
`ifdef FCL_NEURON_ACC_RELU_EN
        out_sat   = acc_q < 0 ? '0 : acc_q > SAT_MAX ? OUT_MAX : acc_q[OUT_WIDTH-1:0];
`else
        out_sat   = acc_q > SAT_MAX ? OUT_MAX : acc_q < SAT_MIN ? ~OUT_MAX : acc_q[OUT_WIDTH-1:0];
`endif
        acc_d     = (state_q == IDLE && accept) ? psum_ext :
                    (state_q == ACCUM && accept) ? acc_q + psum_ext :
                    (state_q == BIAS) ? acc_q + bias_ext : acc_q;
        cnt_d     = (state_q == IDLE && accept) ? CNT_W'(1) :
                    (state_q == ACCUM && accept) ? cnt_q + 1'b1 :
                    out_fire ? '0 : cnt_q;
        bias_d    = (state_q == IDLE && accept) ? bus.neuron_acc_bias_i : bias_q;
        out_d     = (state_q == OUT && !valid_q) ? out_sat : out_q;
        valid_d   = (state_q == OUT && !valid_q) ? 1'b1 : out_fire ? 1'b0 : valid_q;
        idx_d     = !out_fire ? idx_q : idx_q == IDX_W'(NUM_NEURONS-1) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge neuron_acc_clk or posedge neuron_acc_rst) begin
        if (neuron_acc_rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            bias_q  <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_fcl_neuron_accum.sv
// tb_fcl_neuron_accum: directed stimulus with a result scoreboard for fcl_neuron_accum.
module tb_fcl_neuron_accum;
    localparam int PSUM_W = 19;
    localparam int OUT_W  = 16;
    localparam int IDX_W  = 7;

    typedef struct {
        int out;
        int idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   exp_idx = 0;
    exp_t exp_q[$];
    exp_t e;

    fcl_neuron_accum_if #(.PSUM_WIDTH(PSUM_W), .OUT_WIDTH(OUT_W), .IDX_WIDTH(IDX_W)) bus();

    fcl_neuron_accum dut (
        .neuron_acc_clk(clk),
        .neuron_acc_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.neuron_acc_out_valid_o && bus.neuron_acc_out_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0d want none", $signed(bus.neuron_acc_out_o));
            end else begin
                e = exp_q.pop_front();
                chk("result", int'($signed(bus.neuron_acc_out_o)), e.out);
                chk("result_idx", int'(bus.neuron_acc_idx_o), e.idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.neuron_acc_psum_ready_o && n < 1000) begin
            tick();
            n++;
        end
        if (n == 1000) chk("ready_timeout", 0, 1);
    endtask

    task automatic send_beats(input int cnt, input int v, input int b, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            bus.neuron_acc_psum_i       = PSUM_W'(v);
            bus.neuron_acc_bias_i       = OUT_W'(b);
            bus.neuron_acc_psum_valid_i = 1'b1;
            wait_ready();
            tick();
            bus.neuron_acc_psum_valid_i = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic send_neuron(input int v, input int b, input int expv, input bit gaps);
        exp_q.push_back('{expv, exp_idx});
        exp_idx = (exp_idx == 119) ? 0 : exp_idx + 1;
        send_beats(40, v, b, gaps);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_idx = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string n);
        chk({n, "_out"}, int'($signed(bus.neuron_acc_out_o)), 0);
        chk({n, "_idx"}, int'(bus.neuron_acc_idx_o), 0);
        chk({n, "_valid"}, int'(bus.neuron_acc_out_valid_o), 0);
    endtask

    initial begin
        int n;
        bus.neuron_acc_psum_i       = '0;
        bus.neuron_acc_psum_valid_i = 1'b0;
        bus.neuron_acc_bias_i       = '0;
        bus.neuron_acc_out_ready_i  = 1'b1;
        do_reset();
        chk_idle_outputs("reset");
        chk("reset_ready", int'(bus.neuron_acc_psum_ready_o), 1);

        send_neuron(100, 5, 4005, 1'b0);
        chk("bias_ready", int'(bus.neuron_acc_psum_ready_o), 0);
        tick();
        chk("lat_edge1_valid", int'(bus.neuron_acc_out_valid_o), 0);
        tick();
        chk("lat_edge2_valid", int'(bus.neuron_acc_out_valid_o), 1);
        chk("lat_edge2_out", int'($signed(bus.neuron_acc_out_o)), 4005);
        tick();
        chk("pulse_valid", int'(bus.neuron_acc_out_valid_o), 0);
        chk("after_ready", int'(bus.neuron_acc_psum_ready_o), 1);

        send_neuron(262143, 0, 32767, 1'b0);
`ifdef FCL_NEURON_ACC_RELU_EN
        send_neuron(-1000, 0, 0, 1'b0);
`else
        send_neuron(-1000, 0, -32768, 1'b0);
`endif
        send_neuron(100, 5, 4005, 1'b1);
        drain();

        bus.neuron_acc_out_ready_i = 1'b0;
        send_neuron(2, -7, 73, 1'b0);
        n = 0;
        while (!bus.neuron_acc_out_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk("bp_valid_seen", int'(bus.neuron_acc_out_valid_o), 1);
        bus.neuron_acc_psum_i       = PSUM_W'(1);
        bus.neuron_acc_bias_i       = '0;
        bus.neuron_acc_psum_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_hold", int'($signed(bus.neuron_acc_out_o)), 73);
            chk("bp_idx_hold", int'(bus.neuron_acc_idx_o), 4);
            chk("bp_valid_hold", int'(bus.neuron_acc_out_valid_o), 1);
            chk("bp_psum_ready", int'(bus.neuron_acc_psum_ready_o), 0);
            tick();
        end
        bus.neuron_acc_out_ready_i = 1'b1;
        send_neuron(1, 0, 40, 1'b0);
        drain();

        send_beats(10, 50, 9, 1'b0);
        #2 rst = 1'b1;
        #1 chk_idle_outputs("midrst");
        exp_q.delete();
        exp_idx = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_idle_outputs("postrst");
        chk("postrst_ready", int'(bus.neuron_acc_psum_ready_o), 1);
        send_neuron(1, 2, 42, 1'b0);
        drain();

        do_reset();
        for (int i = 0; i < 121; i++) send_neuron(1, 0, 40, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
